// File: rtl/mmio_bus_pkg.sv
// Shared constants for the CPU-to-peripheral MMIO bus controller:
// FSM state encoding, the default peripheral address tags and the
// width of the ACCESS-state timeout counter.
package mmio_bus_pkg;

    // Controller FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [1:0] ST_ERR    = 2'd3;

    // Default address tags (cpu_addr[31:28]) of the existing peripherals
    localparam logic [3:0] TAG_LED = 4'hF;
    localparam logic [3:0] TAG_SEG = 4'hE;
    localparam logic [3:0] TAG_CNT = 4'h2;
    localparam logic [3:0] TAG_RAM = 4'h0;

    // Timeout counter width; large enough for TIMEOUT up to 65535
    localparam int TMO_W = 16;

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational address-tag decoder. Compares the incoming tag against
// every slave's tag and returns a one-hot select plus a hit flag. When
// several slaves share a tag, the lowest index wins.
module mmio_addr_decode #(
    parameter int NUM_SLAVES = 4,
    parameter int TAG_W      = 4,
    parameter logic [NUM_SLAVES*TAG_W-1:0] SLV_TAGS = '0
) (
    input  logic [TAG_W-1:0]      tag,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  hit
);

    // Scan from the highest index down so the lowest matching index is
    // the last one written and therefore takes priority.
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (tag == SLV_TAGS[i*TAG_W +: TAG_W]) begin
                sel    = '0;
                sel[i] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// MMIO bus controller: one CPU master, NUM_SLAVES tag-decoded slaves.
// An access is latched in IDLE, the selected slave is strobed in ACCESS
// until it acks (or the timeout expires), then RESP/ERR drives a single
// cpu_ready pulse.
//
// Handshake: cpu_req is held high by the CPU until it sees cpu_ready;
// cpu_ready is a one-cycle pulse and cpu_rdata/cpu_err are only valid in
// that cycle. A slave completes by raising its slv_ack bit while its
// slv_sel bit is high; the ack is consumed at that clock edge.
//
// Optional build macro MMIO_BUS_ERR_CAPTURE_EN adds err_addr (last
// faulting address) and err_count (saturating error counter).
import mmio_bus_pkg::*;

module mmio_bus_ctrl #(
    parameter int NUM_SLAVES = 4,
    parameter int TAG_W      = 4,
    parameter logic [NUM_SLAVES*TAG_W-1:0] SLV_TAGS = {TAG_LED, TAG_SEG, TAG_CNT, TAG_RAM},
    parameter int SLV_ADDR_W = 12,
    parameter int TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [31:0]              cpu_addr,
    input  logic [31:0]              cpu_wdata,
    output logic [31:0]              cpu_rdata,
    output logic                     cpu_ready,
    output logic                     cpu_err,
    output logic [NUM_SLAVES-1:0]    slv_sel,
    output logic [NUM_SLAVES-1:0]    slv_we,
    output logic [SLV_ADDR_W-1:0]    slv_addr,
    output logic [31:0]              slv_wdata,
    input  logic [NUM_SLAVES*32-1:0] slv_rdata,
    input  logic [NUM_SLAVES-1:0]    slv_ack
`ifdef MMIO_BUS_ERR_CAPTURE_EN
   ,output logic [31:0]              err_addr,
    output logic [15:0]              err_count
`endif
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [1:0]            state;
    logic [NUM_SLAVES-1:0] sel_q;
    logic                  we_q;
    logic [31:0]           rdata_q;
    logic [TMO_W-1:0]      tmo_cnt;

    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_hit;
    logic                  ack_sel;
    logic [31:0]           rdata_mux;
    logic                  start;
    logic                  tmo_hit;
    logic                  unused_addr_bits;

    // Middle address bits are neither tag nor slave-local offset
    assign unused_addr_bits = ^cpu_addr;

    mmio_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .TAG_W      (TAG_W),
        .SLV_TAGS   (SLV_TAGS)
    ) u_decode (
        .tag (cpu_addr[31 -: TAG_W]),
        .sel (dec_sel),
        .hit (dec_hit)
    );

    assign start   = (state == ST_IDLE) && cpu_req;
    assign ack_sel = |(slv_ack & sel_q);
    assign tmo_hit = (state == ST_ACCESS) && !ack_sel && (tmo_cnt == TMO_LAST);

    // Read-data mux: only the latched (selected) slave contributes
    always_comb begin
        rdata_mux = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                rdata_mux = rdata_mux | slv_rdata[i*32 +: 32];
            end
        end
    end

    // Controller FSM, request latch and timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sel_q     <= '0;
            we_q      <= 1'b0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            rdata_q   <= '0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        we_q      <= cpu_we;
                        slv_addr  <= cpu_addr[SLV_ADDR_W-1:0];
                        slv_wdata <= cpu_wdata;
                        sel_q     <= dec_sel;
                        tmo_cnt   <= '0;
                        state     <= dec_hit ? ST_ACCESS : ST_ERR;
                    end
                end
                ST_ACCESS: begin
                    // An ack wins over a timeout expiring in the same cycle
                    if (ack_sel) begin
                        rdata_q <= we_q ? 32'h0 : rdata_mux;
                        state   <= ST_RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state   <= ST_ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus outputs decoded from state; strobes only live in ACCESS
    always_comb begin
        slv_sel   = (state == ST_ACCESS) ? sel_q : '0;
        slv_we    = (state == ST_ACCESS && we_q) ? sel_q : '0;
        cpu_ready = (state == ST_RESP) || (state == ST_ERR);
        cpu_err   = (state == ST_ERR);
        cpu_rdata = (state == ST_RESP) ? rdata_q : 32'h0;
    end

`ifdef MMIO_BUS_ERR_CAPTURE_EN
    logic [31:0] fault_addr_q;

    // Error capture: remember the address of every failed access
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_addr_q <= '0;
            err_addr     <= '0;
            err_count    <= '0;
        end else begin
            if (start) begin
                fault_addr_q <= cpu_addr;
            end
            if ((start && !dec_hit) || tmo_hit) begin
                err_addr <= start ? cpu_addr : fault_addr_q;
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
            end
        end
    end
`else
    logic unused_err_terms;
    assign unused_err_terms = start ^ tmo_hit;
`endif

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Testbench for mmio_bus_ctrl: table of directed accesses, a few
// hand-written multi-cycle sequences (reset mid-access, back-to-back with
// stray ack) and randomized accesses checked against a transaction-level
// reference model through an expected-result queue.
module tb_mmio_bus_ctrl;

    localparam int TMO = 8;
    localparam int W   = 53;  // {lat[7:0], err, sel[3:0], selcyc[7:0], rdata[31:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         cpu_req = 1'b0;
    logic         cpu_we = 1'b0;
    logic [31:0]  cpu_addr = '0;
    logic [31:0]  cpu_wdata = '0;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         cpu_err;
    logic [3:0]   slv_sel;
    logic [3:0]   slv_we;
    logic [11:0]  slv_addr;
    logic [31:0]  slv_wdata;
    logic [127:0] slv_rdata;
    logic [3:0]   slv_ack = '0;
`ifdef MMIO_BUS_ERR_CAPTURE_EN
    logic [31:0]  err_addr;
    logic [15:0]  err_count;
`endif

    logic [31:0] slave_data [4];
    logic [3:0]  slave_tag  [4] = '{4'hF, 4'hE, 4'hE, 4'h0};

    assign slv_rdata = {slave_data[3], slave_data[2], slave_data[1], slave_data[0]};

    mmio_bus_ctrl #(
        .NUM_SLAVES (4),
        .TAG_W      (4),
        .SLV_TAGS   (16'h0EEF),
        .SLV_ADDR_W (12),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .slv_sel   (slv_sel),
        .slv_we    (slv_we),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_rdata (slv_rdata),
        .slv_ack   (slv_ack)
`ifdef MMIO_BUS_ERR_CAPTURE_EN
       ,.err_addr  (err_addr),
        .err_count (err_count)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: which slave owns the tag, how many
    // cycles until cpu_ready, and what the CPU should see.
    function automatic logic [W-1:0] model(input logic we, input logic [31:0] addr, input int delay);
        int idx;
        logic [7:0] lat, sc;
        logic err;
        logic [3:0] sel;
        logic [31:0] rd;
        idx = -1;
        for (int i = 0; i < 4; i++)
            if (idx < 0 && slave_tag[i] == addr[31:28]) idx = i;
        if (idx < 0) begin
            lat = 8'd1; err = 1'b1; sel = 4'b0; sc = 8'd0; rd = 32'h0;
        end else begin
            sel = 4'(1 << idx);
            if (delay < TMO) begin
                lat = 8'(delay + 2); sc = 8'(delay + 1); err = 1'b0;
                rd  = we ? 32'h0 : slave_data[idx];
            end else begin
                lat = 8'(TMO + 1); sc = 8'(TMO); err = 1'b1; rd = 32'h0;
            end
        end
        return {lat, err, sel, sc, rd};
    endfunction

    // ---------------- driver ----------------
    // Drives one access and plays the slave: the selected slave acks in
    // its (delay+1)-th select cycle; 'stray' acks are held throughout.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int delay, input logic [3:0] stray, input logic b2b, input logic hold,
                             output int lat, output logic err, output logic [31:0] rdata,
                             output logic [3:0] sel, output int selcyc, output logic stable,
                             output logic gap_ok);
        int k;
        logic done;
        if (!b2b) @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        slv_ack = stray;
        lat = -1; err = 1'b0; rdata = '0; sel = '0; selcyc = 0; stable = 1'b1; done = 1'b0; k = 0;
        while (!done && k < 40) begin
            @(posedge clk); #1;
            k++;
            slv_ack = stray;
            if (slv_sel != 4'b0) begin
                selcyc++;
                if (sel == 4'b0) sel = slv_sel;
                else if (slv_sel != sel) stable = 1'b0;
                if (slv_addr != addr[11:0] || slv_wdata != wdata ||
                    slv_we != (we ? slv_sel : 4'b0) || cpu_ready) stable = 1'b0;
                if (selcyc == 1) begin
                    cpu_addr = $urandom; cpu_wdata = $urandom; cpu_we = 1'($urandom);
                end
                if (selcyc == delay + 1) slv_ack = slv_ack | slv_sel;
            end
            if (cpu_ready) begin
                lat = k; err = cpu_err; rdata = cpu_rdata; done = 1'b1;
            end
        end
        if (!hold) cpu_req = 1'b0;
        @(posedge clk); #1;
        gap_ok = !cpu_ready && (slv_sel == 4'b0) && (cpu_rdata == 32'h0);
        slv_ack = '0;
    endtask

    task automatic run_one(input string name, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int delay, input logic [3:0] stray,
                           input logic b2b, input logic hold);
        int lat, selcyc;
        logic err, stable, gap_ok;
        logic [31:0] rdata;
        logic [3:0] sel;
        logic [W-1:0] e;
        do_access(we, addr, wdata, delay, stray, b2b, hold, lat, err, rdata, sel, selcyc, stable, gap_ok);
        if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s: expected queue empty", name);
        end else begin
            e = exp_q.pop_front();
            check({name, ".latency"}, 64'(lat), 64'(e[52:45]));
            check({name, ".err"},     64'(err), 64'(e[44]));
            check({name, ".sel"},     64'(sel), 64'(e[43:40]));
            check({name, ".selcyc"},  64'(selcyc), 64'(e[39:32]));
            check({name, ".rdata"},   64'(rdata), 64'(e[31:0]));
            check({name, ".stable"},  64'(stable), 64'd1);
            check({name, ".gap"},     64'(gap_ok), 64'd1);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [3:0]  stray;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_sel;
        int          exp_selcyc;
    } vec_t;

    vec_t vecs [7];

    initial begin
        slave_data = '{32'h0BAD_F00D, 32'hC0DE_1111, 32'h2222_2222, 32'h1234_5678};

        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         0,   4'b0000, 2, 1'b0, 32'h1234_5678, 4'b1000, 1};
        vecs[1] = '{1'b1, 32'hF000_0000, 32'hDEAD_BEEF, 5,   4'b0000, 7, 1'b0, 32'h0,         4'b0001, 6};
        vecs[2] = '{1'b0, 32'h7000_0000, 32'h0,         0,   4'b0000, 1, 1'b1, 32'h0,         4'b0000, 0};
        vecs[3] = '{1'b0, 32'hE000_0004, 32'h0,         100, 4'b0000, 9, 1'b1, 32'h0,         4'b0010, 8};
        vecs[4] = '{1'b0, 32'hE000_0008, 32'h0,         7,   4'b0000, 9, 1'b0, 32'hC0DE_1111, 4'b0010, 8};
        vecs[5] = '{1'b0, 32'hF000_0ABC, 32'h0,         2,   4'b0100, 4, 1'b0, 32'h0BAD_F00D, 4'b0001, 3};
        vecs[6] = '{1'b1, 32'h2000_0000, 32'h1111_2222, 0,   4'b0000, 1, 1'b1, 32'h0,         4'b0000, 0};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset.ready", 64'(cpu_ready), 64'd0);
        check("reset.err",   64'(cpu_err), 64'd0);
        check("reset.rdata", 64'(cpu_rdata), 64'd0);
        check("reset.sel_we", 64'({slv_sel, slv_we}), 64'd0);
        check("reset.addr_wdata", 64'({slv_addr, slv_wdata}), 64'd0);

        // directed table
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({8'(vecs[i].exp_lat), vecs[i].exp_err, vecs[i].exp_sel,
                             8'(vecs[i].exp_selcyc), vecs[i].exp_rdata});
            run_one($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].delay, vecs[i].stray, 1'b0, 1'b0);
        end
`ifdef MMIO_BUS_ERR_CAPTURE_EN
        check("errcap.count", 64'(err_count), 64'd3);
        check("errcap.addr",  64'(err_addr), 64'h2000_0000);
`endif

        // reset in the 3rd ACCESS cycle aborts without a ready pulse
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hF000_0123; cpu_wdata = 32'h5555_AAAA;
        begin
            logic seen_ready;
            seen_ready = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                if (cpu_ready) seen_ready = 1'b1;
            end
            check("rstmid.in_access", 64'(slv_sel), 64'b0001);
            rst = 1'b1;
            @(posedge clk); #1;
            if (cpu_ready) seen_ready = 1'b1;
            check("rstmid.outputs", 64'({cpu_ready, cpu_err, slv_sel, slv_we}), 64'd0);
            check("rstmid.data", 64'({cpu_rdata, slv_wdata}), 64'd0);
            check("rstmid.addr", 64'(slv_addr), 64'd0);
            rst = 1'b0; cpu_req = 1'b0;
            @(posedge clk); #1;
            if (cpu_ready) seen_ready = 1'b1;
            check("rstmid.no_ready", 64'(seen_ready), 64'd0);
        end
        exp_q.push_back(model(1'b0, 32'h0000_0044, 1));
        run_one("after_rst", 1'b0, 32'h0000_0044, 32'h0, 1, 4'b0000, 1'b0, 1'b0);

        // back-to-back with cpu_req held high, stray ack from slave 2
        exp_q.push_back(model(1'b0, 32'hF000_0008, 3));
        run_one("b2b_a", 1'b0, 32'hF000_0008, 32'h0, 3, 4'b0100, 1'b0, 1'b1);
        exp_q.push_back(model(1'b1, 32'h0000_0FFC, 0));
        run_one("b2b_b", 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 0, 4'b0000, 1'b1, 1'b0);

        // randomized accesses against the model
        for (int n = 0; n < 40; n++) begin
            logic [3:0] tags [6];
            logic [31:0] addr;
            logic we;
            int delay, j;
            logic [W-1:0] e;
            logic [3:0] stray;
            tags = '{4'hF, 4'hE, 4'h0, 4'h2, 4'h7, 4'($urandom)};
            for (int s = 0; s < 4; s++) slave_data[s] = $urandom;
            addr  = {tags[$urandom_range(0, 5)], 28'($urandom)};
            we    = 1'($urandom);
            delay = $urandom_range(0, 10);
            e     = model(we, addr, delay);
            j     = $urandom_range(0, 3);
            stray = (e[40 + j] == 1'b1) ? 4'b0 : 4'(1 << j);
            exp_q.push_back(e);
            run_one($sformatf("rnd%0d", n), we, addr, $urandom, delay, stray, 1'b0, 1'b0);
        end

        check("scoreboard.drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_bus_ctrl.md
Name: mmio_bus_ctrl

Overview:
- Parametrised memory-mapped bus controller; next generation of the SoC's CPU-to-peripheral bus.
- Connects one CPU master to NUM_SLAVES slaves (RAM, counter, GPIO, 7-seg, VGA, future devices).
- Slaves are selected by address tag; each slave may insert wait states via an ack handshake.
- Drives the CPU ready input (the existing MIO_ready hook); flags unmapped or timed-out accesses as errors.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..8).
- TAG_W, 4, width of address tag cpu_addr[31:32-TAG_W] used for decode.
- SLV_TAGS, {4'hF,4'hE,4'h2,4'h0}, NUM_SLAVES*TAG_W concatenated tags; slave i owns SLV_TAGS[i*TAG_W +: TAG_W].
- SLV_ADDR_W, 12, slave-local address width; slv_addr = cpu_addr[SLV_ADDR_W-1:0].
- TIMEOUT, 255, max ACCESS cycles waiting for ack before error (1..65535).

Ports:
- clk  in  1  bus clock.
- rst  in  1  synchronous active-high reset.
- cpu_req  in  1  access request; held high until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data; valid while cpu_ready is high.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  high with cpu_ready when the access failed.
- slv_sel  out  NUM_SLAVES  one-hot slave select.
- slv_we  out  NUM_SLAVES  one-hot write strobe (subset of slv_sel).
- slv_addr  out  SLV_ADDR_W  latched local address.
- slv_wdata  out  32  latched write data.
- slv_rdata  in  NUM_SLAVES*32  slave read data; slave i at [i*32 +: 32].
- slv_ack  in  NUM_SLAVES  slave completion; sampled only for the selected slave.

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high.
- Reset outputs: all outputs 0, FSM to IDLE, timeout counter 0. Reset mid-access aborts without a ready pulse.
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE:
  - On cpu_req=1: latch addr/wdata/we and decode the tag.
  - Exactly one slave matches: go to ACCESS.
  - No match: go to ERR.
  - Multiple matches: lowest index wins (static priority).
- ACCESS:
  - slv_sel[i]=1; slv_we[i]=latched we.
  - slv_addr and slv_wdata are held stable for the whole state.
  - slv_ack[i]=1 at a clock edge: capture slv_rdata[i] (reads only; writes capture 0), go to RESP.
  - Otherwise increment the timeout counter. When the counter reaches TIMEOUT-1 with no ack, go to ERR.
  - An ack and the timeout in the same cycle resolve to ack (RESP).
- RESP: cpu_ready=1, cpu_err=0, cpu_rdata=captured data for exactly one cycle; then IDLE.
- ERR: cpu_ready=1, cpu_err=1, cpu_rdata=0 for exactly one cycle; then IDLE.
- Latency: request sampled at edge N, slv_sel high in cycle N+1. A zero-wait ack in N+1 gives cpu_ready in N+2 (2-cycle minimum). Each wait state adds 1 cycle.
- Back-to-back: cpu_req still high in a RESP/ERR cycle is ignored; the next access is sampled in IDLE.
- Stray acks: acks from unselected slaves and any ack outside ACCESS are ignored.
- Outside ACCESS: slv_sel and slv_we are 0. slv_addr and slv_wdata keep their last latched value.
- Input changes during an access: cpu_addr/cpu_wdata/cpu_we changes after latch have no effect.
- Timeout counter: cleared on entry to ACCESS; it never wraps.

Optional Feature:
- Macro: MMIO_BUS_ERR_CAPTURE_EN.
- Defined: adds outputs err_addr (32) and err_count (16).
  - err_addr latches the faulting cpu_addr on every ERR entry.
  - err_count increments per error and saturates at 16'hFFFF.
  - Both reset to 0.
- Undefined: neither port exists and no error-capture logic is present; all other behaviour is identical.

Decomposition:
- Package mmio_bus_pkg:
  - FSM state encoding localparams (IDLE=0, ACCESS=1, RESP=2, ERR=3).
  - Default tag constants (TAG_LED=4'hF, TAG_SEG=4'hE, TAG_CNT=4'h2, TAG_RAM=4'h0).
  - Counter width for TIMEOUT.
- Sub-module mmio_addr_decode: purely combinational tag compare producing one-hot select plus hit, with lowest-index priority.

Test Plan:
- Zero-wait read: slave 3 (tag 0) acks immediately with rdata 32'h1234_5678; read 32'h0000_0010 → slv_sel=4'b1000 in N+1, cpu_ready with cpu_rdata=32'h1234_5678, cpu_err=0 in N+2.
- Wait-state write: write 32'hDEAD_BEEF to 32'hF000_0000, slave 0 acks after 5 cycles → slv_we[0] held high 6 cycles, slv_wdata stable; cpu_ready one cycle after ack; cpu_rdata=0.
- Unmapped: read 32'h7000_0000 → ERR at N+1: cpu_ready=1, cpu_err=1, cpu_rdata=0, no slv_sel ever asserted. With MMIO_BUS_ERR_CAPTURE_EN: err_addr=32'h7000_0000, err_count=1.
- Timeout: TIMEOUT=8, slave 1 never acks → slv_sel[1] high 8 cycles, then cpu_err pulse. Rerun with ack on the 8th cycle → RESP, no error.
- Reset mid-access: rst asserted in the 3rd ACCESS cycle → next cycle all outputs 0, no cpu_ready; a fresh request afterwards completes normally.
- Back-to-back and stray ack: cpu_req held high across two accesses → each gets its own single cpu_ready pulse, separated by an IDLE cycle. slv_ack[2] pulsed while slave 0 is selected → ignored.
